bitonic_sorter_pipe: RTL and testbench
======================================

Name: bitonic_sorter_pipe

Overview:
Parametrised, fully pipelined bitonic sorting network that sorts N = 2**N_LOG2 unsigned keys per vector, in ascending or descending order chosen per vector. It succeeds the fixed 8-input, 8-bit combinational merge stage: it contains the full sort (all build and merge layers), adds a register after every comparator layer, and uses valid/ready flow control. It sits between a vector producer and a consumer in the sorting datapath and accepts one vector per cycle.

Parameters:
DATA_W, 8, key width in bits (unsigned)
N_LOG2, 3, log2 of lane count; legal values 1..4 (N = 2..16)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector this cycle
in_desc  in  1  1 = descending (lane 0 largest), 0 = ascending (lane 0 smallest)
in_data  in  N*DATA_W  lane i = in_data[i*DATA_W +: DATA_W]
out_valid  out  1  sorted vector valid
out_ready  in  1  consumer accepts the vector
out_desc  out  1  in_desc carried with the vector
out_data  out  N*DATA_W  sorted lanes, same packing as in_data

Behaviour:
- Stages: L = N_LOG2*(N_LOG2+1)/2 comparator layers (L = 6 for N = 8). Each layer has N/2 compare-swap units feeding a register stage that holds the data, a valid bit and the desc bit.
- Network: standard bitonic build and merge. The direction of each sub-merge comes from lane index bits, and the final merge direction comes from the stage's desc bit.
- Compare-swap: swap only when strictly out of order. Equal keys are never swapped. Unsigned compare on DATA_W bits.
- Flow control: global advance enable adv = !out_valid | out_ready.
  - in_ready = adv, combinational.
  - When adv = 1, all stages shift by one. Stage 0 loads in_valid / in_data / in_desc.
  - When adv = 0, all stages hold, including the output.
- Bubbles (valid = 0) propagate and occupy a slot. Stages are not compressed.
- Transfer on input when in_valid & in_ready; transfer on output when out_valid & out_ready.
- Latency: a vector accepted at edge k presents out_valid = 1 after edge k+L, provided there are no stalls. Throughput is 1 vector per cycle.
- out_data, out_valid and out_desc are driven directly from the last stage register; there is no combinational path from in_data to out_data.
- Holding: while out_valid = 1 and out_ready = 0, out_data and out_desc stay stable.
- Reset (async, any time, including mid-stream): all valid bits go to 0 and all data/desc registers to 0. Hence out_valid = 0, out_data = 0, out_desc = 0. In-flight vectors are discarded. in_ready = 1 as soon as rst_n is deasserted.
- in_data is ignored when in_valid = 0. X on in_data must not reach out_valid.
- Simultaneous input accept and output drain in the same cycle is normal operation and involves no extra state.

Optional Feature:
Macro: BITONIC_SORTER_INDEX_EN
- Defined:
  - Adds output port out_idx, width N*N_LOG2.
  - Lane j of out_idx is the original input lane number of the key now in out_data lane j.
  - Index tags are initialised to i at stage 0, move with their key through every swap, and reset to 0.
  - Tie rule unchanged: on equal keys, tags keep their order.
- Undefined: port and tag registers are absent. Behaviour is otherwise identical.

Decomposition:
- Package bitonic_pkg:
  - function n_layers(n_log2), returning L.
  - function layer_partner(layer, lane), returning the partner lane and a direction bit.
  - Localparams for N and L derived from the module parameters.
- Sub-module bitonic_cas: parametrised by DATA_W and tag width. Inputs a, b, dir and two tags; outputs lo/hi in the requested order, purely combinational. It is instantiated N/2 times per layer through generate loops.
- The stage registers and the advance logic live in the top module.

Test Plan:
- Descending: N=8, DATA_W=8, lanes 0..7 = {3,7,4,8,6,2,1,5}, in_desc=1, out_ready=1 -> after 6 cycles, out_data lanes = {8,7,6,5,4,3,2,1}. With the index feature, out_idx = {3,1,4,7,2,0,5,6}.
- Ascending and duplicates:
  - {5,5,0,255,5,0,255,5}, in_desc=0 -> {0,0,5,5,5,5,255,255}.
  - All lanes 0x5A -> unchanged output; with the index feature, out_idx = {0,1,2,3,4,5,6,7}.
- Streaming and mixed modes: 20 random vectors back to back with alternating in_desc -> 20 outputs in order, each correctly sorted, out_desc matches, no gaps after the first L cycles.
- Backpressure: stream 10 vectors while holding out_ready=0 for cycles 8..13 -> in_ready=0 in exactly those cycles, out_data held stable, no vector lost or duplicated, output order preserved.
- Reset mid-stream: assert rst_n=0 with 4 vectors in flight -> out_valid=0 and out_data=0 immediately (asynchronous). After release, the first new vector appears exactly L cycles after acceptance, with no stale outputs.
- Parameter sweep: N_LOG2=1,2,4 and DATA_W=16, checked against a reference sorting model -> L = 1, 3, 10 respectively and all outputs correct.

Source files
------------

// File: rtl/bitonic_pkg.sv
// Shared helpers for the pipelined bitonic sorter: layer count and the
// per-layer lane pairing of the standard bitonic build/merge network.
package bitonic_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_LOG2 = 3;

  typedef struct packed {
    logic [4:0] partner;
    logic       dir;      // 1 = this block sorts descending
  } partner_t;

  function automatic int n_layers(input int n_log2);
    return n_log2 * (n_log2 + 1) / 2;
  endfunction

  // Layer numbering: stage s (block size 2**s) contributes s layers whose
  // compare distance shrinks from 2**(s-1) down to 1.
  function automatic partner_t layer_partner(input int layer, input int lane);
    int       s;
    int       base;
    int       t;
    partner_t p;
    s    = 1;
    base = 0;
    for (int k = 0; k < 8; k++) begin
      if (layer >= base + s) begin
        base += s;
        s++;
      end
    end
    t         = s - 1 - (layer - base);
    p.partner = 5'(lane ^ (1 << t));
    p.dir     = ((lane >> s) & 1) != 0;
    return p;
  endfunction

  localparam int DEF_N = 1 << DEF_N_LOG2;
  localparam int DEF_L = n_layers(DEF_N_LOG2);

endpackage

// File: rtl/bitonic_cas.sv
// Combinational compare-swap: swaps only when strictly out of order.
// Tag ports exist only when BITONIC_SORTER_INDEX_EN is defined.
module bitonic_cas #(
  parameter int DATA_W = 8
`ifdef BITONIC_SORTER_INDEX_EN
  , parameter int TAG_W = 3
`endif
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_dir,
`ifdef BITONIC_SORTER_INDEX_EN
  input  logic [TAG_W-1:0]  i_a_tag,
  input  logic [TAG_W-1:0]  i_b_tag,
  output logic [TAG_W-1:0]  o_lo_tag,
  output logic [TAG_W-1:0]  o_hi_tag,
`endif
  output logic [DATA_W-1:0] o_lo,
  output logic [DATA_W-1:0] o_hi
);

  logic w_swap;

  assign w_swap = i_dir ? (i_a < i_b) : (i_a > i_b);
  assign o_lo   = w_swap ? i_b : i_a;
  assign o_hi   = w_swap ? i_a : i_b;

`ifdef BITONIC_SORTER_INDEX_EN
  assign o_lo_tag = w_swap ? i_b_tag : i_a_tag;
  assign o_hi_tag = w_swap ? i_a_tag : i_b_tag;
`endif

endmodule

// File: rtl/bitonic_sorter_pipe.sv
// Fully pipelined bitonic sorter, one register stage per comparator layer,
// single global advance enable. Define BITONIC_SORTER_INDEX_EN for out_idx.
module bitonic_sorter_pipe
  import bitonic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_LOG2 = DEF_N_LOG2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_desc,
  input  logic [(1<<N_LOG2)*DATA_W-1:0]    in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_desc,
  output logic [(1<<N_LOG2)*DATA_W-1:0]    out_data
`ifdef BITONIC_SORTER_INDEX_EN
  , output logic [(1<<N_LOG2)*N_LOG2-1:0]  out_idx
`endif
);

  localparam int N           = 1 << N_LOG2;
  localparam int L           = n_layers(N_LOG2);
  localparam int FINAL_FIRST = L - N_LOG2;

  logic [DATA_W-1:0] w_src  [L][N];
  logic [DATA_W-1:0] w_cas  [L][N];
  logic              w_vsrc [L];
  logic              w_dsrc [L];
  logic [DATA_W-1:0] r_data [L][N];
  logic              r_valid[L];
  logic              r_desc [L];
  logic              w_adv;

`ifdef BITONIC_SORTER_INDEX_EN
  localparam int IDX_W = N_LOG2;
  logic [IDX_W-1:0] w_tsrc [L][N];
  logic [IDX_W-1:0] w_tcas [L][N];
  logic [IDX_W-1:0] r_tag  [L][N];
`endif

  generate
    for (genvar l = 0; l < L; l++) begin : g_layer
      if (l == 0) begin : g_first
        assign w_vsrc[0] = in_valid;
        assign w_dsrc[0] = in_desc;
        for (genvar i = 0; i < N; i++) begin : g_lane
          assign w_src[0][i] = in_data[i*DATA_W +: DATA_W];
`ifdef BITONIC_SORTER_INDEX_EN
          assign w_tsrc[0][i] = IDX_W'(i);
`endif
        end
      end else begin : g_next
        assign w_vsrc[l] = r_valid[l-1];
        assign w_dsrc[l] = r_desc[l-1];
        for (genvar i = 0; i < N; i++) begin : g_lane
          assign w_src[l][i] = r_data[l-1][i];
`ifdef BITONIC_SORTER_INDEX_EN
          assign w_tsrc[l][i] = r_tag[l-1][i];
`endif
        end
      end

      // Build stages take their direction from the lane bits; the final
      // merge stage takes it from the vector's own desc bit.
      for (genvar i = 0; i < N; i++) begin : g_cas
        localparam partner_t P     = layer_partner(l, i);
        localparam int       PI    = int'(P.partner);
        localparam bit       FINAL = (l >= FINAL_FIRST);
        if (PI > i) begin : g_unit
          bitonic_cas #(
            .DATA_W(DATA_W)
`ifdef BITONIC_SORTER_INDEX_EN
            , .TAG_W(IDX_W)
`endif
          ) u_cas (
            .i_a     (w_src[l][i]),
            .i_b     (w_src[l][PI]),
            .i_dir   (FINAL ? w_dsrc[l] : P.dir),
`ifdef BITONIC_SORTER_INDEX_EN
            .i_a_tag (w_tsrc[l][i]),
            .i_b_tag (w_tsrc[l][PI]),
            .o_lo_tag(w_tcas[l][i]),
            .o_hi_tag(w_tcas[l][PI]),
`endif
            .o_lo    (w_cas[l][i]),
            .o_hi    (w_cas[l][PI])
          );
        end
      end
    end
  endgenerate

  // NOTE: in_ready is combinational from the output stage; a stalled output
  // freezes every stage, so the pipeline never drops or compresses slots.
  assign w_adv    = !r_valid[L-1] || out_ready;
  assign in_ready = w_adv;

  // NOTE: the data registers are reset as well, since out_data must read 0
  // while reset is asserted, not just out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < L; l++) begin
        r_valid[l] <= 1'b0;
        r_desc[l]  <= 1'b0;
        for (int i = 0; i < N; i++) begin
          r_data[l][i] <= '0;
`ifdef BITONIC_SORTER_INDEX_EN
          r_tag[l][i]  <= '0;
`endif
        end
      end
    end else if (w_adv) begin
      for (int l = 0; l < L; l++) begin
        r_valid[l] <= w_vsrc[l];
        r_desc[l]  <= w_dsrc[l];
        for (int i = 0; i < N; i++) begin
          r_data[l][i] <= w_cas[l][i];
`ifdef BITONIC_SORTER_INDEX_EN
          r_tag[l][i]  <= w_tcas[l][i];
`endif
        end
      end
    end
  end

  assign out_valid = r_valid[L-1];
  assign out_desc  = r_desc[L-1];

  generate
    for (genvar i = 0; i < N; i++) begin : g_out
      assign out_data[i*DATA_W +: DATA_W] = r_data[L-1][i];
`ifdef BITONIC_SORTER_INDEX_EN
      assign out_idx[i*IDX_W +: IDX_W] = r_tag[L-1][i];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_bitonic_sorter_pipe.sv
// Self-checking bench for bitonic_sorter_pipe: directed table, streaming,
// backpressure, mid-stream reset and a small parameter sweep.
module tb_bitonic_sorter_pipe;

  localparam int LAT = 6;

  typedef logic [15:0] key_t;
  typedef key_t vec_t [16];

  typedef struct packed {
    logic [63:0] din;
    logic        desc;
    logic [63:0] dout;
    logic [23:0] didx;
    logic        chk_idx;
  } vec_rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_desc, out_valid, out_ready, out_desc;
  logic [63:0] in_data, out_data;

  logic         sw_valid, sw_desc;
  logic [255:0] sw_data;
  logic         s1_ready, s1_valid, s1_desc;
  logic         s2_ready, s2_valid, s2_desc;
  logic         s4_ready, s4_valid, s4_desc;
  logic [31:0]  s1_data;
  logic [63:0]  s2_data;
  logic [255:0] s4_data;

`ifdef BITONIC_SORTER_INDEX_EN
  logic [23:0] out_idx;
  logic [1:0]  s1_idx;
  logic [7:0]  s2_idx;
  logic [63:0] s4_idx;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  bitonic_sorter_pipe #(.DATA_W(8), .N_LOG2(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_desc(in_desc), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_desc(out_desc), .out_data(out_data)
`ifdef BITONIC_SORTER_INDEX_EN
    , .out_idx(out_idx)
`endif
  );

  bitonic_sorter_pipe #(.DATA_W(16), .N_LOG2(1)) u_sw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s1_ready),
    .in_desc(sw_desc), .in_data(sw_data[31:0]), .out_valid(s1_valid),
    .out_ready(1'b1), .out_desc(s1_desc), .out_data(s1_data)
`ifdef BITONIC_SORTER_INDEX_EN
    , .out_idx(s1_idx)
`endif
  );

  bitonic_sorter_pipe #(.DATA_W(16), .N_LOG2(2)) u_sw2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s2_ready),
    .in_desc(sw_desc), .in_data(sw_data[63:0]), .out_valid(s2_valid),
    .out_ready(1'b1), .out_desc(s2_desc), .out_data(s2_data)
`ifdef BITONIC_SORTER_INDEX_EN
    , .out_idx(s2_idx)
`endif
  );

  bitonic_sorter_pipe #(.DATA_W(16), .N_LOG2(4)) u_sw4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s4_ready),
    .in_desc(sw_desc), .in_data(sw_data), .out_valid(s4_valid),
    .out_ready(1'b1), .out_desc(s4_desc), .out_data(s4_data)
`ifdef BITONIC_SORTER_INDEX_EN
    , .out_idx(s4_idx)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] v8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int          a[8] = '{a0, a1, a2, a3, a4, a5, a6, a7};
    logic [63:0] r    = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(a[i]);
    return r;
  endfunction

  function automatic logic [23:0] i8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int          a[8] = '{a0, a1, a2, a3, a4, a5, a6, a7};
    logic [23:0] r    = '0;
    for (int i = 0; i < 8; i++) r[i*3 +: 3] = 3'(a[i]);
    return r;
  endfunction

  // Reference model: plain insertion sort of the first n keys.
  function automatic vec_t ref_sort(input vec_t v, input int n, input bit desc);
    vec_t r = v;
    key_t t;
    for (int i = 1; i < n; i++)
      for (int j = i; j > 0; j--)
        if (desc ? (r[j] > r[j-1]) : (r[j] < r[j-1])) begin
          t = r[j]; r[j] = r[j-1]; r[j-1] = t;
        end
    return r;
  endfunction

  function automatic logic [255:0] pack16(input vec_t v, input int n);
    logic [255:0] p = '0;
    for (int i = 0; i < n; i++) p[i*16 +: 16] = v[i];
    return p;
  endfunction

  function automatic logic [63:0] pack_idx(input vec_t v, input int n, input int nl);
    logic [63:0] p = '0;
    for (int j = 0; j < n; j++)
      for (int b = 0; b < nl; b++) p[j*nl + b] = v[j][b];
    return p;
  endfunction

  function automatic logic [63:0] exp8(input logic [63:0] din, input bit desc);
    vec_t        k = '{default: '0};
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++) k[i] = 16'(din[i*8 +: 8]);
    k = ref_sort(k, 8, desc);
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = k[i][7:0];
    return r;
  endfunction

  // Latency counts rising edges from the negedge the vector is driven
  // until out_valid is seen on a later negedge.
  task automatic send_one(input vec_rec_t r, input string tag);
    int lat = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = r.din; in_desc = r.desc;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_data"}, out_data, r.dout);
    check({tag, "_desc"}, out_desc, r.desc);
`ifdef BITONIC_SORTER_INDEX_EN
    if (r.chk_idx) check({tag, "_idx"}, out_idx, r.didx);
`endif
  endtask

  task automatic run_stream(input string tag, input int nvec, input int bp_lo, input int bp_hi);
    logic [63:0] exp_q[$];
    logic        exp_dq[$];
    int          sent = 0, got = 0, first = -1, cyc = 0;
    logic        held_v = 1'b0, held_desc = 1'b0, bp, desc;
    logic [63:0] held_d = '0, din;
    while (got < nvec && cyc < 300) begin
      @(negedge clk);
      bp = (cyc >= bp_lo) && (cyc <= bp_hi);
      out_ready = !bp;
      #1;
      if (bp_lo >= 0) check($sformatf("%s_in_ready_c%0d", tag, cyc), in_ready, !bp);
      if (held_v) begin
        check($sformatf("%s_hold_data_c%0d", tag, cyc), out_data, held_d);
        check($sformatf("%s_hold_desc_c%0d", tag, cyc), out_desc, held_desc);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check({tag, "_extra_output"}, out_valid, 1'b0);
        else begin
          check($sformatf("%s_data_%0d", tag, got), out_data, exp_q.pop_front());
          check($sformatf("%s_desc_%0d", tag, got), out_desc, exp_dq.pop_front());
        end
        if (first < 0) first = cyc;
        else if (bp_lo < 0) check($sformatf("%s_gap_%0d", tag, got), cyc, first + got);
        got++;
      end
      held_v = out_valid && !out_ready; held_d = out_data; held_desc = out_desc;
      if (in_ready && sent < nvec) begin
        din  = {$urandom(), $urandom()};
        desc = (sent % 2) != 0;
        in_valid = 1'b1; in_data = din; in_desc = desc;
        exp_q.push_back(exp8(din, desc));
        exp_dq.push_back(desc);
        sent++;
      end else in_valid = 1'b0;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, got, nvec);
    check({tag, "_first_latency"}, first, LAT);
  endtask

  task automatic sweep_one(input int v);
    vec_t         k, e1, e2, e4;
    logic         desc;
    int           seen1 = 0, seen2 = 0, seen4 = 0;
    for (int i = 0; i < 16; i++) k[i] = {8'($urandom_range(0, 255)), 8'(i)};
    desc = (v % 2) != 0;
    e1 = ref_sort(k, 2, desc);
    e2 = ref_sort(k, 4, desc);
    e4 = ref_sort(k, 16, desc);
    @(negedge clk);
    sw_valid = 1'b1; sw_desc = desc; sw_data = pack16(k, 16);
    #1;
    check($sformatf("sw%0d_ready", v), {s1_ready, s2_ready, s4_ready}, 3'b111);
    for (int lat = 1; lat <= 14; lat++) begin
      @(negedge clk);
      sw_valid = 1'b0;
      if (s1_valid) begin
        seen1++;
        check($sformatf("sw%0d_n2_latency", v), lat, 1);
        check($sformatf("sw%0d_n2_data", v), s1_data, pack16(e1, 2));
        check($sformatf("sw%0d_n2_desc", v), s1_desc, desc);
`ifdef BITONIC_SORTER_INDEX_EN
        check($sformatf("sw%0d_n2_idx", v), s1_idx, pack_idx(e1, 2, 1));
`endif
      end
      if (s2_valid) begin
        seen2++;
        check($sformatf("sw%0d_n4_latency", v), lat, 3);
        check($sformatf("sw%0d_n4_data", v), s2_data, pack16(e2, 4));
        check($sformatf("sw%0d_n4_desc", v), s2_desc, desc);
`ifdef BITONIC_SORTER_INDEX_EN
        check($sformatf("sw%0d_n4_idx", v), s2_idx, pack_idx(e2, 4, 2));
`endif
      end
      if (s4_valid) begin
        seen4++;
        check($sformatf("sw%0d_n16_latency", v), lat, 10);
        check($sformatf("sw%0d_n16_data", v), s4_data, pack16(e4, 16));
        check($sformatf("sw%0d_n16_desc", v), s4_desc, desc);
`ifdef BITONIC_SORTER_INDEX_EN
        check($sformatf("sw%0d_n16_idx", v), s4_idx, pack_idx(e4, 16, 4));
`endif
      end
    end
    check($sformatf("sw%0d_outputs_seen", v), {8'(seen1), 8'(seen2), 8'(seen4)}, 24'h010101);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_rec_t tbl[6];
    tbl[0] = '{din: v8(3,7,4,8,6,2,1,5), desc: 1'b1, dout: v8(8,7,6,5,4,3,2,1),
               didx: i8(3,1,4,7,2,0,5,6), chk_idx: 1'b1};
    tbl[1] = '{din: v8(5,5,0,255,5,0,255,5), desc: 1'b0, dout: v8(0,0,5,5,5,5,255,255),
               didx: '0, chk_idx: 1'b0};
    tbl[2] = '{din: v8(90,90,90,90,90,90,90,90), desc: 1'b1, dout: v8(90,90,90,90,90,90,90,90),
               didx: i8(0,1,2,3,4,5,6,7), chk_idx: 1'b1};
    tbl[3] = '{din: v8(3,7,4,8,6,2,1,5), desc: 1'b0, dout: v8(1,2,3,4,5,6,7,8),
               didx: i8(6,5,0,2,7,4,1,3), chk_idx: 1'b1};
    tbl[4] = '{din: v8(10,20,30,40,50,60,70,80), desc: 1'b1, dout: v8(80,70,60,50,40,30,20,10),
               didx: i8(7,6,5,4,3,2,1,0), chk_idx: 1'b1};
    tbl[5] = '{din: v8(255,0,255,0,1,254,128,127), desc: 1'b0, dout: v8(0,0,1,127,128,254,255,255),
               didx: '0, chk_idx: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_desc = 1'b0; in_data = '0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_desc = 1'b0; sw_data = '0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_data", out_data, 64'h0);
    check("reset_out_desc", out_desc, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1'b1);

    for (int t = 0; t < 6; t++) send_one(tbl[t], $sformatf("vec%0d", t));

    run_stream("stream", 20, -1, -1);
    run_stream("bp", 10, 8, 13);

    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      #1;
      in_valid = (c < 4);
      in_data  = {$urandom(), $urandom()};
      in_desc  = (c % 2) != 0;
    end
    in_valid = 1'b0;
    check("midrst_pre_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 64'h0);
    check("midrst_out_desc", out_desc, 1'b0);
`ifdef BITONIC_SORTER_INDEX_EN
    check("midrst_out_idx", out_idx, 24'h0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("midrst_no_stale_c%0d", c), out_valid, 1'b0);
    end
    send_one(tbl[0], "post_midrst");

    for (int v = 0; v < 4; v++) sweep_one(v);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
